// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the LSU (priority) and the coprocessor, with a starvation guard and a bus timeout.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_read,
  input  logic                  lsu_write,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_done,
  output logic                  lsu_err,
  input  logic                  cp_read,
  input  logic                  cp_write,
  input  logic [ADDR_WIDTH-1:0] cp_addr,
  input  logic [DATA_WIDTH-1:0] cp_wdata,
  output logic [DATA_WIDTH-1:0] cp_rdata,
  output logic                  cp_done,
  output logic                  cp_err,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_write_data,
  output logic                  dmem_read,
  output logic                  dmem_write,
  input  logic [DATA_WIDTH-1:0] dmem_read_data,
  input  logic                  dmem_ready,
  output logic                  busy
);
  localparam int SW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, GRANT_LSU, GRANT_CP} state_t;
  state_t state, state_n;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic lsu_req, cp_req, pick_cp, expire, finish;
  // A requester still showing its done pulse is masked so a held request is not served twice.
  always_comb begin
    lsu_req = (lsu_read | lsu_write) & ~lsu_done;
    cp_req = (cp_read | cp_write) & ~cp_done;
    pick_cp = cp_req & (~lsu_req | (starve_cnt == SW'(STARVE_LIMIT)));
    expire = (TIMEOUT_CYCLES != 0) && !dmem_ready && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    finish = dmem_ready | expire;
    state_n = state;
    if (state == IDLE) state_n = pick_cp ? GRANT_CP : lsu_req ? GRANT_LSU : IDLE;
    else if (finish) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      dmem_addr <= '0;
      dmem_write_data <= '0;
      dmem_read <= 1'b0;
      dmem_write <= 1'b0;
      lsu_rdata <= '0;
      cp_rdata <= '0;
      lsu_done <= 1'b0;
      lsu_err <= 1'b0;
      cp_done <= 1'b0;
      cp_err <= 1'b0;
      starve_cnt <= '0;
      tcnt <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      lsu_done <= 1'b0;
      lsu_err <= 1'b0;
      cp_done <= 1'b0;
      cp_err <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (state_n != IDLE) begin
          dmem_addr <= pick_cp ? cp_addr : lsu_addr;
          dmem_write_data <= pick_cp ? cp_wdata : lsu_wdata;
          dmem_write <= pick_cp ? cp_write : lsu_write;
          dmem_read <= pick_cp ? cp_read & ~cp_write : lsu_read & ~lsu_write;
          starve_cnt <= pick_cp ? '0 :
                        (cp_req && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
        end
      end else if (finish) begin
        dmem_read <= 1'b0;
        dmem_write <= 1'b0;
        if (state == GRANT_LSU) begin
          lsu_done <= 1'b1;
          lsu_err <= expire;
          if (dmem_ready && dmem_read) lsu_rdata <= dmem_read_data;
        end else begin
          cp_done <= 1'b1;
          cp_err <= expire;
          if (dmem_ready && dmem_read) cp_rdata <= dmem_read_data;
        end
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized scoreboard bench; a memory responder encodes each request's latency in its address bits [6:3].
module tb_dmem_port_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;
  typedef struct packed {logic [63:0] rd; logic err;} exp_t;
  logic clk = 0, reset;
  logic lsu_read, lsu_write, cp_read, cp_write;
  logic [63:0] lsu_addr, lsu_wdata, cp_addr, cp_wdata;
  logic [63:0] lsu_rdata, cp_rdata, dmem_addr, dmem_write_data, dmem_read_data;
  logic lsu_done, lsu_err, cp_done, cp_err, dmem_read, dmem_write, dmem_ready, busy;
  int vec = 0, errs = 0;
  exp_t lq[$], cq[$];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] last_rd [2];
  bit lpend = 0, cpend = 0;
  int ln = 0, cn = 0;
  dmem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .lsu_read(lsu_read), .lsu_write(lsu_write), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .cp_read(cp_read), .cp_write(cp_write), .cp_addr(cp_addr), .cp_wdata(cp_wdata),
    .cp_rdata(cp_rdata), .cp_done(cp_done), .cp_err(cp_err),
    .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] init_val(input logic [63:0] a);
    return a ^ 64'h5A5A_0F0F_C3C3_1234;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic fail(input string nm);
    vec++;
    errs++;
    $display("FAIL %s at %0t", nm, $time);
  endtask
  // Builds a request, derives its expected response from the memory rules, and drives it.
  task automatic issue(input int p, input int flat, input int fop);
    logic [63:0] a, w;
    logic [3:0] lat;
    logic r, wr;
    int k;
    exp_t e;
    k = $urandom_range(0, 9);
    lat = flat > 0 ? 4'(flat) : k < 4 ? 4'd1 : k < 6 ? 4'd2 : k == 6 ? 4'd3 : k == 7 ? 4'd8 : k == 8 ? 4'd9 : 4'd15;
    a = (64'(p) << 40) | (64'($urandom_range(0, 7)) << 7) | (64'(lat) << 3);
    w = {$urandom, $urandom};
    k = fop < 0 ? $urandom_range(0, 4) : fop;
    wr = k >= 3;
    r = k != 3;
    e.err = lat > 4'(TO);
    e.rd = (!wr && !e.err) ? (ref_mem.exists(a) ? ref_mem[a] : init_val(a)) : last_rd[p];
    if (wr && !e.err) ref_mem[a] = w;
    last_rd[p] = e.rd;
    if (p == 0) begin
      lq.push_back(e);
      lsu_addr = a; lsu_wdata = w; lsu_read = r; lsu_write = wr;
      lpend = 1; ln++;
    end else begin
      cq.push_back(e);
      cp_addr = a; cp_wdata = w; cp_read = r; cp_write = wr;
      cpend = 1; cn++;
    end
  endtask
  task automatic step(input int nt);
    @(posedge clk); #1;
    if (lpend) begin
      if (lsu_done) lpend = 0;
    end else if (ln < nt && $urandom_range(0, 2) == 0) issue(0, 0, -1);
    else begin lsu_read = 0; lsu_write = 0; end
    if (cpend) begin
      if (cp_done) cpend = 0;
    end else if (cn < nt && $urandom_range(0, 2) == 0) issue(1, 0, -1);
    else begin cp_read = 0; cp_write = 0; end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && (lpend || cpend); i++) step(0);
    if (lpend || cpend) begin
      fail("drain_timeout");
      lpend = 0; cpend = 0;
    end
    step(0);
  endtask
  // Memory: ready on the lat-th strobe cycle; random ready noise while no strobe is up.
  initial begin
    int gcnt;
    gcnt = 0; dmem_ready = 0; dmem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (dmem_read | dmem_write) begin
        gcnt++;
        if (gcnt == int'(dmem_addr[6:3])) begin
          dmem_ready = 1;
          if (dmem_write) mem[dmem_addr] = dmem_write_data;
          dmem_read_data = mem.exists(dmem_addr) ? mem[dmem_addr] : init_val(dmem_addr);
        end else begin
          dmem_ready = 0; dmem_read_data = {$urandom, $urandom};
        end
      end else begin
        gcnt = 0; dmem_ready = $urandom_range(0, 3) == 0; dmem_read_data = {$urandom, $urandom};
      end
    end
  end
  // Monitor: transaction-level model of the shared port, checked every cycle.
  initial begin
    int cyc, m_end, m_owner, mask, starve, lat;
    bit m_idle, chk_zero, fin, d, ed, lr, cr, w;
    logic [63:0] ga, gw;
    logic gr, gwr;
    exp_t e;
    cyc = 0; m_end = -1; m_owner = 0; mask = 2; starve = 0; m_idle = 1; chk_zero = 0;
    ga = '0; gw = '0; gr = 0; gwr = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_zero) begin
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_write_data, 0);
        chk("rst_rdata", lsu_rdata | cp_rdata, 0);
        chk("rst_ctl", {busy, dmem_read, dmem_write, lsu_done, lsu_err, cp_done, cp_err}, 0);
        chk_zero = 0;
      end
      if (reset) begin
        m_idle = 1; m_end = -1; mask = 2; starve = 0; chk_zero = 1;
        lq.delete(); cq.delete();
        continue;
      end
      fin = cyc == m_end;
      for (int p = 0; p < 2; p++) begin
        d = p == 1 ? cp_done : lsu_done;
        ed = fin && m_owner == p;
        chk($sformatf("done%0d", p), 64'(d), 64'(ed));
        if ((d || ed) && (p == 1 ? cq.size() : lq.size()) > 0) begin
          if (p == 1) e = cq.pop_front();
          else e = lq.pop_front();
          chk($sformatf("rdata%0d", p), p == 1 ? cp_rdata : lsu_rdata, e.rd);
          chk($sformatf("err%0d", p), 64'(p == 1 ? cp_err : lsu_err), 64'(e.err));
        end else if (d) fail($sformatf("unexpected_done%0d", p));
        else chk($sformatf("err_idle%0d", p), 64'(p == 1 ? cp_err : lsu_err), 0);
      end
      if (fin) begin m_idle = 1; mask = m_owner; end
      chk("busy", 64'(busy), 64'(!m_idle));
      if (m_idle) chk("strobes_idle", {dmem_read, dmem_write}, 0);
      else begin
        chk("dmem_addr", dmem_addr, ga);
        chk("dmem_wdata", dmem_write_data, gw);
        chk("strobes", {dmem_read, dmem_write}, {gr, gwr});
      end
      if (m_idle) begin
        lr = (lsu_read | lsu_write) && mask != 0;
        cr = (cp_read | cp_write) && mask != 1;
        if (lr || cr) begin
          w = cr && (!lr || starve == SL);
          starve = w ? 0 : (cr && starve < SL) ? starve + 1 : starve;
          ga = w ? cp_addr : lsu_addr;
          gw = w ? cp_wdata : lsu_wdata;
          gwr = w ? cp_write : lsu_write;
          gr = (w ? cp_read : lsu_read) && !gwr;
          lat = int'(ga[6:3]);
          m_end = cyc + 1 + (lat < TO ? lat : TO);
          m_owner = int'(w);
          m_idle = 0;
        end
      end
      mask = 2;
    end
  end
  initial begin
    last_rd[0] = '0; last_rd[1] = '0;
    reset = 1; lsu_read = 1; lsu_write = 0; cp_read = 0; cp_write = 1;
    lsu_addr = 64'h1000; lsu_wdata = '0; cp_addr = 64'h2000; cp_wdata = 64'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    reset = 0; lsu_read = 0; cp_write = 0;
    @(posedge clk); #1;
    issue(0, 1, 0);
    wait_idle();
    @(posedge clk); #1;
    issue(1, 15, 3);
    wait_idle();
    @(posedge clk); #1;
    issue(1, TO, 0);
    wait_idle();
    @(posedge clk); #1;
    issue(0, 2, -1);
    issue(1, 2, -1);
    wait_idle();
    for (int n = 0; n < 8000 && (ln < 160 || cn < 160 || lpend || cpend); n++) step(160);
    if (lpend || cpend) fail("random_phase_timeout");
    wait_idle();
    @(posedge clk); #1;
    issue(0, 15, 0);
    for (int i = 0; i < 10 && !dmem_read; i++) begin @(posedge clk); #1; end
    if (!dmem_read) fail("grant_wait_timeout");
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    lpend = 0; last_rd[0] = '0; last_rd[1] = '0;
    issue(0, 1, 0);
    wait_idle();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
